// File: rtl/dtmf_tone_sequencer_if.sv
// Dial request/response bundle between the Nios PIO and the DTMF tone sequencer.
// The PIO side (master) drives the key code, start and abort.
// The sequencer side (slave) returns the mixed tone level and the handshake status.
interface dtmf_tone_sequencer_if;
    logic [3:0] digit_in;
    logic       start;
    logic       abort;
    logic [1:0] tone_out;
    logic       tone_active;
    logic       ready;
    logic       done;

    modport master (
        output digit_in, start, abort,
        input  tone_out, tone_active, ready, done
    );

    modport slave (
        input  digit_in, start, abort,
        output tone_out, tone_active, ready, done
    );
endinterface

// File: rtl/dtmf_tone_sequencer.sv
// Plays one DTMF key: a row+column square-wave mix for TONE_MS, then silence for GAP_MS.
// Latency: burst starts the cycle after start; tone_out lags row_clks/col_clks by one cycle.
// Backpressure: start is only taken while ready=1; a start during a burst or gap is dropped.
module dtmf_tone_sequencer #(
    parameter int TICKS_PER_MS = 1000,
    parameter int TONE_MS      = 50,
    parameter int GAP_MS       = 50
) (
    input  logic                    clk_1m_in,
    input  logic                    reset_b,
    input  logic [3:0]              row_clks,
    input  logic [3:0]              col_clks,
    dtmf_tone_sequencer_if.slave    dial
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TONE = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [9:0] TICK_LAST = 10'(TICKS_PER_MS - 1);
    localparam logic [7:0] TONE_LAST = 8'(TONE_MS - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_MS - 1);

    state_t     state;
    logic [9:0] tick_cnt;
    logic [7:0] ms_cnt;
    logic [1:0] row_sel;
    logic [1:0] col_sel;
    logic [1:0] tone_out_q;
    logic       tone_active_q;
    logic       ready_q;
    logic       done_q;

    logic [1:0] key_row;
    logic [1:0] key_col;
    logic       tick_last;
    logic [1:0] mix;

    assign tick_last = (tick_cnt == TICK_LAST);
    assign mix       = {1'b0, row_clks[row_sel]} + {1'b0, col_clks[col_sel]};

    // Standard telephone keypad layout: key code to (row, column) of the 4x4 grid.
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (dial.digit_in)
            4'h1: begin key_row = 2'd0; key_col = 2'd0; end
            4'h2: begin key_row = 2'd0; key_col = 2'd1; end
            4'h3: begin key_row = 2'd0; key_col = 2'd2; end
            4'hA: begin key_row = 2'd0; key_col = 2'd3; end
            4'h4: begin key_row = 2'd1; key_col = 2'd0; end
            4'h5: begin key_row = 2'd1; key_col = 2'd1; end
            4'h6: begin key_row = 2'd1; key_col = 2'd2; end
            4'hB: begin key_row = 2'd1; key_col = 2'd3; end
            4'h7: begin key_row = 2'd2; key_col = 2'd0; end
            4'h8: begin key_row = 2'd2; key_col = 2'd1; end
            4'h9: begin key_row = 2'd2; key_col = 2'd2; end
            4'hC: begin key_row = 2'd2; key_col = 2'd3; end
            4'hE: begin key_row = 2'd3; key_col = 2'd0; end
            4'h0: begin key_row = 2'd3; key_col = 2'd1; end
            4'hF: begin key_row = 2'd3; key_col = 2'd2; end
            default: begin key_row = 2'd3; key_col = 2'd3; end
        endcase
    end

    // Burst/gap sequencer with registered outputs; abort overrides everything.
    always_ff @(posedge clk_1m_in or negedge reset_b) begin
        if (!reset_b) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            ms_cnt        <= '0;
            row_sel       <= '0;
            col_sel       <= '0;
            tone_out_q    <= '0;
            tone_active_q <= 1'b0;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (dial.abort) begin
                state         <= IDLE;
                tick_cnt      <= '0;
                ms_cnt        <= '0;
                tone_out_q    <= '0;
                tone_active_q <= 1'b0;
                ready_q       <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        tone_out_q <= '0;
                        if (dial.start) begin
                            state         <= TONE;
                            row_sel       <= key_row;
                            col_sel       <= key_col;
                            tick_cnt      <= '0;
                            ms_cnt        <= '0;
                            tone_active_q <= 1'b1;
                            ready_q       <= 1'b0;
                        end
                    end
                    TONE: begin
                        if (tick_last && ms_cnt == TONE_LAST) begin
                            // Last tick of the burst: silence the output on the same edge.
                            state         <= GAP;
                            tick_cnt      <= '0;
                            ms_cnt        <= '0;
                            tone_out_q    <= '0;
                            tone_active_q <= 1'b0;
                        end else begin
                            tone_out_q <= mix;
                            if (tick_last) begin
                                tick_cnt <= '0;
                                ms_cnt   <= ms_cnt + 8'd1;
                            end else begin
                                tick_cnt <= tick_cnt + 10'd1;
                            end
                        end
                    end
                    GAP: begin
                        tone_out_q <= '0;
                        if (tick_last && ms_cnt == GAP_LAST) begin
                            state    <= IDLE;
                            tick_cnt <= '0;
                            ms_cnt   <= '0;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                        end else if (tick_last) begin
                            tick_cnt <= '0;
                            ms_cnt   <= ms_cnt + 8'd1;
                        end else begin
                            tick_cnt <= tick_cnt + 10'd1;
                        end
                    end
                    default: begin
                        state         <= IDLE;
                        tone_out_q    <= '0;
                        tone_active_q <= 1'b0;
                        ready_q       <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign dial.tone_out    = tone_out_q;
    assign dial.tone_active = tone_active_q;
    assign dial.ready       = ready_q;
    assign dial.done        = done_q;

endmodule

// File: tb/tb_dtmf_tone_sequencer.sv
// Directed bench for dtmf_tone_sequencer with 4 ticks/ms, 3 ms burst, 2 ms gap.
// Inputs change and outputs are sampled on the falling edge of the 1 MHz clock.
// Expected values come from the keypad table and the 12/8-cycle burst/gap timing.
`timescale 1ns/1ps
module tb_dtmf_tone_sequencer;

    localparam int T  = 4;
    localparam int TM = 3;
    localparam int GM = 2;

    logic       clk_1m_in = 1'b0;
    logic       reset_b   = 1'b0;
    logic [3:0] row_clks  = 4'h0;
    logic [3:0] col_clks  = 4'h0;

    int tests = 0;
    int fails = 0;

    int exp_row [16] = '{3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 0, 1, 2, 3, 3, 3};
    int exp_col [16] = '{1, 0, 1, 2, 0, 1, 2, 0, 1, 2, 3, 3, 3, 3, 0, 2};

    dtmf_tone_sequencer_if dial ();

    dtmf_tone_sequencer #(
        .TICKS_PER_MS (T),
        .TONE_MS      (TM),
        .GAP_MS       (GM)
    ) dut (
        .clk_1m_in (clk_1m_in),
        .reset_b   (reset_b),
        .row_clks  (row_clks),
        .col_clks  (col_clks),
        .dial      (dial.slave)
    );

    always #500 clk_1m_in = ~clk_1m_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_1m_in);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] mix;
        int r;
        int c;

        dial.digit_in = 4'h0;
        dial.start    = 1'b0;
        dial.abort    = 1'b0;

        // Reset values
        #1200;
        check("rst_ready", 32'(dial.ready), 1);
        check("rst_active", 32'(dial.tone_active), 0);
        check("rst_tone", 32'(dial.tone_out), 0);
        check("rst_done", 32'(dial.done), 0);
        tick();
        reset_b = 1'b1;
        tick();

        // Digit 5: 12 cycles of tone_active, 8 cycles of gap, one-cycle done
        dial.digit_in = 4'h5;
        dial.start    = 1'b1;
        tick();
        dial.start = 1'b0;
        check("t1_act_n", 32'(dial.tone_active), 1);
        check("t1_ready_n", 32'(dial.ready), 0);
        check("t1_tone_n", 32'(dial.tone_out), 0);
        for (int k = 1; k <= 21; k++) begin
            row_clks = 4'(k * 3);
            col_clks = 4'(k * 7);
            mix = 2'({1'b0, row_clks[1]} + {1'b0, col_clks[1]});
            tick();
            check($sformatf("t1_tone_k%0d", k), 32'(dial.tone_out), (k <= 11) ? 32'(mix) : 0);
            check($sformatf("t1_act_k%0d", k), 32'(dial.tone_active), (k <= 11) ? 1 : 0);
            check($sformatf("t1_ready_k%0d", k), 32'(dial.ready), (k >= 20) ? 1 : 0);
            check($sformatf("t1_done_k%0d", k), 32'(dial.done), (k == 20) ? 1 : 0);
        end

        // Walk all 16 key codes with static one-hot row/col patterns
        for (int d = 0; d < 16; d++) begin
            r = exp_row[d];
            c = exp_col[d];
            row_clks = 4'(1 << r);
            col_clks = 4'(1 << c);
            dial.digit_in = 4'(d);
            dial.start    = 1'b1;
            tick();
            dial.start = 1'b0;
            tick();
            check($sformatf("walk_hit_d%0d", d), 32'(dial.tone_out), 2);
            col_clks = ~col_clks;
            tick();
            check($sformatf("walk_row_only_d%0d", d), 32'(dial.tone_out), 1);
            row_clks = ~row_clks;
            tick();
            check($sformatf("walk_miss_d%0d", d), 32'(dial.tone_out), 0);
            dial.abort = 1'b1;
            tick();
            dial.abort = 1'b0;
            check($sformatf("walk_abort_ready_d%0d", d), 32'(dial.ready), 1);
        end

        // Start with a different digit mid-burst is ignored
        row_clks = 4'b0010;
        col_clks = 4'b0010;
        dial.digit_in = 4'h5;
        dial.start    = 1'b1;
        tick();
        dial.start = 1'b0;
        for (int k = 1; k <= 21; k++) begin
            if (k >= 3 && k <= 5) begin
                dial.digit_in = 4'hD;
                dial.start    = 1'b1;
            end else begin
                dial.start = 1'b0;
            end
            tick();
            check($sformatf("mid_tone_k%0d", k), 32'(dial.tone_out), (k <= 11) ? 2 : 0);
            check($sformatf("mid_ready_k%0d", k), 32'(dial.ready), (k >= 20) ? 1 : 0);
            check($sformatf("mid_done_k%0d", k), 32'(dial.done), (k == 20) ? 1 : 0);
        end

        // Abort at cycle 5 of the burst, then abort together with start
        dial.digit_in = 4'h5;
        dial.start    = 1'b1;
        tick();
        dial.start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        check("ab_tone_before", 32'(dial.tone_out), 2);
        dial.abort = 1'b1;
        tick();
        check("ab_ready", 32'(dial.ready), 1);
        check("ab_active", 32'(dial.tone_active), 0);
        check("ab_tone", 32'(dial.tone_out), 0);
        check("ab_done", 32'(dial.done), 0);
        dial.start = 1'b1;
        tick();
        check("ab_start_ready", 32'(dial.ready), 1);
        check("ab_start_active", 32'(dial.tone_active), 0);
        dial.abort = 1'b0;
        dial.start = 1'b0;
        for (int k = 0; k < 25; k++) begin
            tick();
            check($sformatf("ab_no_done_%0d", k), 32'(dial.done), 0);
        end

        // Back-to-back digits: start held across the edge that pulses done
        row_clks = 4'b0001;
        col_clks = 4'b0001;
        dial.digit_in = 4'h1;
        dial.start    = 1'b1;
        tick();
        dial.start = 1'b0;
        for (int k = 1; k <= 19; k++) tick();
        check("b2b_ready_k19", 32'(dial.ready), 0);
        dial.digit_in = 4'h9;
        dial.start    = 1'b1;
        tick();
        check("b2b_done", 32'(dial.done), 1);
        check("b2b_ready", 32'(dial.ready), 1);
        check("b2b_active_gap", 32'(dial.tone_active), 0);
        tick();
        dial.start = 1'b0;
        check("b2b_active_next", 32'(dial.tone_active), 1);
        check("b2b_ready_next", 32'(dial.ready), 0);
        check("b2b_done_next", 32'(dial.done), 0);
        row_clks = 4'b0100;
        col_clks = 4'b0100;
        tick();
        check("b2b_new_digit_tone", 32'(dial.tone_out), 2);
        dial.abort = 1'b1;
        tick();
        dial.abort = 1'b0;

        // Asynchronous reset in the middle of the gap
        row_clks = 4'b0010;
        col_clks = 4'b0010;
        dial.digit_in = 4'h5;
        dial.start    = 1'b1;
        tick();
        dial.start = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        check("arst_in_gap_active", 32'(dial.tone_active), 0);
        check("arst_in_gap_ready", 32'(dial.ready), 0);
        #100;
        reset_b = 1'b0;
        #10;
        check("arst_ready", 32'(dial.ready), 1);
        check("arst_active", 32'(dial.tone_active), 0);
        check("arst_tone", 32'(dial.tone_out), 0);
        check("arst_done", 32'(dial.done), 0);
        tick();
        tick();
        reset_b = 1'b1;
        tick();
        dial.start = 1'b1;
        tick();
        dial.start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) check("post_rst_tone", 32'(dial.tone_out), 2);
            if (k == 19) check("post_rst_done_k19", 32'(dial.done), 0);
            if (k == 20) check("post_rst_done_k20", 32'(dial.done), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
